// File: rtl/hex_word_serializer.sv
// Streams a DATA_WIDTH-bit word as ASCII hex characters, most-significant nibble first.
// Optional trailing space separator when HEX_SER_SEPARATOR_EN is defined.
module hex_word_serializer #(
    parameter int unsigned DATA_WIDTH             = 32,
    parameter int unsigned UPPERCASE              = 0,
    parameter int unsigned SUPPRESS_LEADING_ZEROS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_char,
    output logic                  out_last,
    output logic                  busy
);

    localparam int unsigned NIBBLES = DATA_WIDTH / 4;
    localparam int unsigned CW      = $clog2(NIBBLES + 1);

    generate
        if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4 || DATA_WIDTH > 64) begin : g_bad_width
            $error("hex_word_serializer: DATA_WIDTH must be a multiple of 4 in 4..64");
        end
    endgenerate

`ifdef HEX_SER_SEPARATOR_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EMIT = 2'd1, S_SEP = 2'd2} state_t;
`else
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;
`endif

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_count;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [7:0]            r_out_char;
    logic                  r_out_last;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic [CW-1:0]         w_lz;
    logic                  w_lz_found;
    logic                  w_in_ready_nxt;
    logic                  w_out_valid_nxt;
    logic [7:0]            w_out_char_nxt;
    logic                  w_out_last_nxt;

    function automatic logic [7:0] enc_nibble(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return ((UPPERCASE != 0) ? 8'h41 : 8'h61) + {4'h0, nib - 4'd10};
    endfunction

    // Next-state, datapath and registered-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_count_nxt     = r_count;
        w_lz            = '0;
        w_lz_found      = 1'b0;
        w_out_char_nxt  = 8'h00;
        w_out_last_nxt  = 1'b0;

        // Leading-zero count stops one nibble short so an all-zero word still sends "0"
        if (SUPPRESS_LEADING_ZEROS != 0) begin
            for (int i = int'(NIBBLES) - 1; i > 0; i--) begin
                if (!w_lz_found) begin
                    if (in_data[4*i +: 4] == 4'h0) begin
                        w_lz = w_lz + CW'(1);
                    end else begin
                        w_lz_found = 1'b1;
                    end
                end
            end
        end

        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_state_nxt = S_EMIT;
                    w_shift_nxt = in_data << {w_lz, 2'b00};
                    w_count_nxt = CW'(NIBBLES) - w_lz;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_shift_nxt = r_shift << 4;
                    w_count_nxt = r_count - CW'(1);
                    if (r_count == CW'(1)) begin
`ifdef HEX_SER_SEPARATOR_EN
                        w_state_nxt = S_SEP;
`else
                        w_state_nxt = S_IDLE;
`endif
                    end
                end
            end
`ifdef HEX_SER_SEPARATOR_EN
            S_SEP: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase

        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt != S_IDLE);

        case (w_state_nxt)
            S_EMIT: begin
                w_out_char_nxt = enc_nibble(w_shift_nxt[DATA_WIDTH-1 -: 4]);
`ifndef HEX_SER_SEPARATOR_EN
                w_out_last_nxt = (w_count_nxt == CW'(1));
`endif
            end
`ifdef HEX_SER_SEPARATOR_EN
            S_SEP: begin
                w_out_char_nxt = 8'h20;
                w_out_last_nxt = 1'b1;
            end
`endif
            default: begin
                w_out_char_nxt = 8'h00;
                w_out_last_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_char  <= 8'h00;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_char  <= w_out_char_nxt;
            r_out_last  <= w_out_last_nxt;
            r_busy      <= w_out_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule
